// File: rtl/cpu_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_led_pkg
// Description : Shared constants for the LED blinker: Avalon register
//               offsets, CTRL bit positions and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_led_pkg;

    // Avalon word offsets
    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_HP   = 2'd1;
    localparam logic [1:0] REG_DUTY = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_PHASE   = 1;
    localparam int CTRL_RESTART = 2;

    // Default parameter values (14-bit PIO, 1 Hz blink at 50 MHz)
    localparam int DEF_WIDTH      = 14;
    localparam int DEF_HP_W       = 26;
    localparam int DEF_HP_DEFAULT = 25000000;
    localparam int DEF_PWM_W      = 4;

endpackage
`default_nettype wire

// File: rtl/cpu_led_blink_timer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_led_blink_timer
// Description : Half-period counter and blink phase generator.
//               Ports:
//                 clk         - system clock
//                 reset_n     - synchronous active-low reset
//                 half_period - half-period length in clk cycles (0 = frozen)
//                 restart     - one-cycle pulse: counter to 0, phase to 1
//                 phase       - blink phase (1 = masked LEDs lit)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_led_blink_timer #(
    parameter int HP_W = 26
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [HP_W-1:0] half_period,
    input  logic            restart,
    output logic            phase
);

    logic [HP_W-1:0] r_hp_cnt;
    logic            r_phase;
    logic            w_terminal;

    assign w_terminal = (r_hp_cnt == (half_period - HP_W'(1)));

    // Priority: reset, then restart (beats a coincident terminal count),
    // then the frozen zero-period case, then normal counting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hp_cnt <= '0;
            r_phase  <= 1'b1;
        end else if (restart || (half_period == '0)) begin
            r_hp_cnt <= '0;
            r_phase  <= 1'b1;
        end else if (w_terminal) begin
            r_hp_cnt <= '0;
            r_phase  <= ~r_phase;
        end else begin
            r_hp_cnt <= r_hp_cnt + HP_W'(1);
        end
    end

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/cpu_led_blinker.sv
`default_nettype none
// ============================================================================
// Module      : cpu_led_blinker
// Description : LED post-processor behind the PIO: per-bit blinking and
//               global PWM dimming, configured over an Avalon-MM slave.
//               Ports:
//                 clk, reset_n  - clock, synchronous active-low reset
//                 address       - register word address
//                 chipselect    - Avalon select
//                 write_n       - Avalon write strobe (active low)
//                 writedata     - Avalon write data
//                 readdata      - combinational read data (zero wait)
//                 led_in        - LED word from the PIO
//                 led_out       - registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_led_blinker
    import cpu_led_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HP_W       = DEF_HP_W,
    parameter int HP_DEFAULT = DEF_HP_DEFAULT,
    parameter int PWM_W      = DEF_PWM_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led_out
);

    localparam logic [PWM_W:0]  c_duty_full = {1'b1, {PWM_W{1'b0}}};
    localparam logic [HP_W-1:0] c_hp_reset  = HP_W'(HP_DEFAULT);

    logic [WIDTH-1:0] r_mask;
    logic [HP_W-1:0]  r_hp;
    logic [PWM_W:0]   r_duty;
    logic             r_en;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [WIDTH-1:0] r_led;

    logic             w_write;
    logic             w_restart;
    logic             w_phase;
    logic             w_pwm_on;
    logic [PWM_W:0]   w_duty_wr;
    logic [WIDTH-1:0] w_led_nxt;

    assign w_write = chipselect && !write_n;

    // Any HALF_PERIOD write realigns the blink so the new period starts lit.
    assign w_restart = w_write &&
                       ((address == REG_HP) ||
                        ((address == REG_CTRL) && writedata[CTRL_RESTART]));

    // Compare the full write word so large values saturate instead of wrapping.
    assign w_duty_wr = (writedata > 32'(c_duty_full)) ? c_duty_full
                                                      : writedata[PWM_W:0];

    cpu_led_blink_timer #(
        .HP_W        (HP_W)
    ) u_blink_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .half_period (r_hp),
        .restart     (w_restart),
        .phase       (w_phase)
    );

    // Extra MSB lets DUTY == 2^PWM_W exceed every counter value (always on).
    assign w_pwm_on = ({1'b0, r_pwm_cnt} < r_duty);

    always_comb begin
        w_led_nxt = led_in;
        if (r_en) begin
            w_led_nxt = led_in & {WIDTH{w_pwm_on}} & (~r_mask | {WIDTH{w_phase}});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask    <= '0;
            r_hp      <= c_hp_reset;
            r_duty    <= c_duty_full;
            r_en      <= 1'b0;
            r_pwm_cnt <= '0;
            r_led     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_led     <= w_led_nxt;
            if (w_write) begin
                case (address)
                    REG_MASK: r_mask <= writedata[WIDTH-1:0];
                    REG_HP:   r_hp   <= writedata[HP_W-1:0];
                    REG_DUTY: r_duty <= w_duty_wr;
                    REG_CTRL: r_en   <= writedata[CTRL_EN];
                    default:  ;
                endcase
            end
        end
    end

    assign led_out = r_led;

    always_comb begin
        readdata = '0;
        case (address)
            REG_MASK: readdata[WIDTH-1:0] = r_mask;
            REG_HP:   readdata[HP_W-1:0]  = r_hp;
            REG_DUTY: readdata[PWM_W:0]   = r_duty;
            REG_CTRL: begin
                readdata[CTRL_EN]    = r_en;
                readdata[CTRL_PHASE] = w_phase;
            end
            default:  readdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_led_blinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_led_blinker
// Description : Self-checking bench for cpu_led_blinker. A cycle model
//               pushes the expected led_out per edge into a queue; the
//               negedge checker pops and compares. Directed checks cover
//               register reads and the listed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_led_blinker;

    localparam int WIDTH      = 14;
    localparam int HP_W       = 26;
    localparam int HP_DEFAULT = 4;
    localparam int PWM_W      = 2;
    localparam int DUTY_FULL  = 4;
    localparam logic [WIDTH-1:0] ALL1 = 14'h3FFF;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] led_in = '0;
    logic [WIDTH-1:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_led_blinker #(
        .WIDTH      (WIDTH),
        .HP_W       (HP_W),
        .HP_DEFAULT (HP_DEFAULT),
        .PWM_W      (PWM_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- cycle model / scoreboard producer ----------------
    logic [WIDTH-1:0] m_mask  = '0;
    int               m_hp    = HP_DEFAULT;
    int               m_duty  = DUTY_FULL;
    bit               m_en    = 1'b0;
    int               m_cnt   = 0;
    bit               m_phase = 1'b1;
    int               m_pwm   = 0;
    logic [WIDTH-1:0] m_exp;
    bit               m_wr, m_rs;
    logic [WIDTH-1:0] sb_q[$];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_exp = '0;
        end else if (m_en) begin
            m_exp = led_in;
            if (!(m_pwm < m_duty)) m_exp = '0;
            if (!m_phase) m_exp = m_exp & ~m_mask;
        end else begin
            m_exp = led_in;
        end
        sb_q.push_back(m_exp);

        if (!reset_n) begin
            m_mask = '0; m_hp = HP_DEFAULT; m_duty = DUTY_FULL; m_en = 0;
            m_cnt = 0; m_phase = 1; m_pwm = 0;
        end else begin
            m_wr = chipselect && !write_n;
            m_rs = m_wr && (address == 2'd1 || (address == 2'd3 && writedata[2]));
            if (m_rs || m_hp == 0) begin
                m_cnt = 0; m_phase = 1;
            end else if (m_cnt == m_hp - 1) begin
                m_cnt = 0; m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
            m_pwm = (m_pwm + 1) % DUTY_FULL;
            if (m_wr) begin
                case (address)
                    2'd0: m_mask = writedata[WIDTH-1:0];
                    2'd1: m_hp   = int'(writedata[HP_W-1:0]);
                    2'd2: m_duty = (writedata > 32'(DUTY_FULL)) ? DUTY_FULL : int'(writedata);
                    default: m_en = writedata[0];
                endcase
            end
        end
    end

    // ---------------- scoreboard consumer ----------------
    always @(negedge clk) begin
        if (sb_q.size() > 0) check("led_out_sb", 32'(led_out), 32'(sb_q.pop_front()));
    end

    // ---------------- bus tasks (called at a negedge) ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt_on;
        bit found;

        // 1. reset and passthrough
        led_in  = 14'h2A5C;
        reset_n = 1'b0;
        cycles(3);
        check("led_in_reset", 32'(led_out), 32'h0);
        reset_n = 1'b1;
        cycles(2);
        check("passthrough", 32'(led_out), 32'h2A5C);
        bus_read_check("rd_mask_rst", 2'd0, 32'd0);
        bus_read_check("rd_hp_rst",   2'd1, 32'd4);
        bus_read_check("rd_duty_rst", 2'd2, 32'd4);
        bus_read_check("rd_ctrl_rst", 2'd3, 32'd2);

        // 2. blink bits 1:0
        led_in = ALL1;
        bus_write(2'd0, 32'h0003);
        bus_write(2'd3, 32'h1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("hi_bits_steady", 32'(led_out[13:2]), 32'hFFF);
            bus_read_check("ctrl_phase", 2'd3, {30'd0, m_phase, 1'b1});
        end

        // 3. PWM dimming
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'd1);
        cycles(2);
        cnt_on = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (led_out == ALL1) cnt_on++;
            else check("pwm_off_zero", 32'(led_out), 32'h0);
        end
        check("pwm_duty1_count", 32'(cnt_on), 32'd2);
        bus_write(2'd2, 32'd31);
        bus_read_check("duty_saturate", 2'd2, 32'd4);
        cycles(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("duty_full_on", 32'(led_out), 32'(ALL1));
        end
        bus_write(2'd2, 32'd0);
        cycles(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("duty_zero_off", 32'(led_out), 32'h0);
        end

        // 4. zero half-period, then HP = 2
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h0003);
        cycles(5);
        bus_write(2'd1, 32'd0);
        cycles(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hp0_frozen_on", 32'(led_out[1:0]), 32'h3);
        end
        bus_read_check("hp0_phase", 2'd3, 32'd3);
        bus_write(2'd1, 32'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hp2_pattern", 32'(led_out[1:0]), ((i % 4) < 2) ? 32'h3 : 32'h0);
        end

        // 5. restart coincident with terminal count while phase = 1
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == m_hp - 1 && m_phase) found = 1;
            else @(negedge clk);
        end
        check("term_found", 32'(found), 32'd1);
        bus_write(2'd3, 32'd5);
        bus_read_check("restart_wins", 2'd3, 32'd3);
        cycles(1);
        check("restart_on_1", 32'(led_out[1:0]), 32'h3);
        cycles(1);
        check("restart_on_2", 32'(led_out[1:0]), 32'h3);
        cycles(1);
        check("restart_off", 32'(led_out[1:0]), 32'h0);

        // 6. mid-run reset pulse
        bus_write(2'd2, 32'd3);
        cycles(3);
        reset_n = 1'b0;
        led_in  = 14'h1234;
        cycles(1);
        reset_n = 1'b1;
        check("rst_led_zero", 32'(led_out), 32'h0);
        bus_read_check("rst_mask", 2'd0, 32'd0);
        bus_read_check("rst_ctrl", 2'd3, 32'd2);
        bus_read_check("rst_duty", 2'd2, 32'd4);
        cycles(1);
        check("rst_passthru", 32'(led_out), 32'h1234);
        led_in = 14'h0F0F;
        cycles(1);
        check("rst_passthru2", 32'(led_out), 32'h0F0F);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_led_blinker.md
Name: cpu_led_blinker

Overview:
Downstream stage of the 14-bit LED PIO in the alarm-clock NIOS system. It consumes the PIO's LED word and drives the physical LEDs, adding per-bit blinking (alarm ringing, time-set cursor) and global PWM dimming. It is configured through its own small Avalon-MM slave, so software does not have to bit-bang blink timing.

Parameters:
WIDTH, 14, number of LED bits; matches the PIO out_port width.
HP_W, 26, width of the half-period counter and register.
HP_DEFAULT, 25000000, reset half-period in clk cycles (1 Hz blink at 50 MHz).
PWM_W, 4, PWM counter width; the PWM period is 2^PWM_W cycles.

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
address  in  2  Avalon register word address.
chipselect  in  1  Avalon select.
write_n  in  1  Avalon write strobe, active low.
writedata  in  32  Avalon write data.
readdata  out  32  Avalon read data; combinational, zero wait states.
led_in  in  WIDTH  LED word from the PIO out_port.
led_out  out  WIDTH  registered physical LED drive.

Behaviour:
- The design has one clock, clk. All state resets synchronously when reset_n == 0 at a clk rising edge.
- A write occurs when chipselect && !write_n.
- Register map (unused read bits return 0):
  - addr 0 BLINK_MASK[WIDTH-1:0], R/W, reset 0.
  - addr 1 HALF_PERIOD[HP_W-1:0], R/W, reset HP_DEFAULT.
  - addr 2 DUTY[PWM_W:0], R/W, reset 2^PWM_W (full brightness). Written values above 2^PWM_W saturate to 2^PWM_W.
  - addr 3 CTRL: bit0 enable (R/W, reset 0); bit1 phase (RO); bit2 restart (write-1 pulse, reads 0).
- Blink timer:
  - hp_cnt counts 0..HALF_PERIOD-1. On the cycle hp_cnt == HALF_PERIOD-1, hp_cnt returns to 0 and phase toggles.
  - Reset values: phase = 1, hp_cnt = 0.
  - HALF_PERIOD == 0: hp_cnt holds 0 and phase is forced to 1 (blinking frozen on).
  - A write to HALF_PERIOD, or CTRL with bit2 = 1, sets hp_cnt = 0 and phase = 1 on the next edge. If this coincides with a terminal count, the restart wins.
- PWM:
  - pwm_cnt is free-running, PWM_W bits, wraps 2^PWM_W-1 -> 0, reset 0.
  - pwm_on = (pwm_cnt < DUTY). DUTY = 0 means always off; DUTY = 2^PWM_W means always on.
- Output, registered with one clk of latency from led_in:
  - enable = 1: led_out[i] <= led_in[i] & pwm_on & (!BLINK_MASK[i] | phase).
  - enable = 0: led_out <= led_in (pure registered passthrough; timers keep running).
- led_out resets to 0.
- Register writes take effect on the edge of the write; the first affected led_out value appears on the following edge.
- Reset asserted mid-blink or mid-PWM returns every register, counter and led_out to its reset value; there is no partial state.

Decomposition:
- Shared package cpu_led_pkg holds:
  - register offsets (REG_MASK = 0, REG_HP = 1, REG_DUTY = 2, REG_CTRL = 3);
  - CTRL bit indices (CTRL_EN = 0, CTRL_PHASE = 1, CTRL_RESTART = 2);
  - default constants.
- One natural sub-module, cpu_led_blink_timer: the hp_cnt/phase logic with restart and zero-period handling. The PWM counter and Avalon decode stay in the top level.

Test Plan:
- Bench parameters: HP_DEFAULT = 4, PWM_W = 2.
1. Reset, then led_in = 14'h2A5C with enable = 0 -> led_out = 0 during reset; led_out = 14'h2A5C one clk after led_in is stable. Reads return MASK = 0, HP = 4, DUTY = 4, CTRL = 2.
2. Write MASK = 14'h0003, CTRL = 1, led_in = 14'h3FFF -> bits 1:0 are high for 4 clks and low for 4 clks, repeating. Bits 13:2 stay high. CTRL read shows bit1 tracking the phase.
3. Write DUTY = 1 with mask 0 and enable = 1 -> each led_out bit is high 1 of every 4 clks. Write DUTY = 31 -> reads back 4 and led_out stays steady high. Write DUTY = 0 -> led_out = 0.
4. Write HALF_PERIOD = 0 mid-blink -> phase = 1 and masked bits stay on. Write HALF_PERIOD = 2 -> blink resumes, 2 clks on and 2 clks off, starting with on.
5. Write CTRL = 5 (enable plus restart) on the same cycle as a terminal count -> the next edge gives hp_cnt = 0 and phase = 1, not a toggle.
6. Assert reset_n = 0 for one clk during active blink and PWM -> on the next edge led_out = 0, enable = 0 and MASK = 0. After release, led_out follows led_in with 1-clk latency.
